cache_fill_arbiter: RTL and testbench

- Shares the single multi-cycle main memory between the instruction-cache miss path and the data-cache miss/write-through path.
- Sequences 8-word block fills: pipelined issue of the reads, in-order collection of the returned words, and a `done` pulse back to the requesting cache.
- Also performs single-word write-throughs.
- Sits between the two cache controllers and the main memory instance; the CPU stalls on any cache's pending request.

---
 rtl/cache_fill_arbiter.sv | 167 ++++++++++++++++
 tb/tb_cache_fill_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: shares main memory between I-cache block fills and
// D-cache block fills / write-throughs, with pipelined block reads.
module cache_fill_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int WORDS   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req,
  input  logic [15:0]              i_addr,
  input  logic                     d_req,
  input  logic                     d_wr,
  input  logic [15:0]              d_addr,
  input  logic [15:0]              d_wdata,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [15:0]              mem_addr,
  output logic [15:0]              mem_wdata,
  input  logic [15:0]              mem_rdata,
  input  logic                     mem_valid,
  output logic                     i_grant,
  output logic                     d_grant,
  output logic [15:0]              fill_data,
  output logic [$clog2(WORDS)-1:0] fill_idx,
  output logic                     i_fill_valid,
  output logic                     d_fill_valid,
  output logic                     i_done,
  output logic                     d_done
);

  localparam int IdxW = $clog2(WORDS);
  localparam int CntW = IdxW + 1;
  localparam int OffW = $clog2(2 * WORDS);

  localparam logic [CntW-1:0] Full    = CntW'(WORDS);
  localparam logic [CntW-1:0] LastIdx = CntW'(WORDS - 1);
  localparam logic [CntW-1:0] MaxOut  =
    CntW'((MEM_LAT < WORDS) ? MEM_LAT : WORDS);
  localparam logic [15:0]     BlkMask = ~16'((1 << OffW) - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL_I,
    FILL_D,
    WRITE
  } state_t;

  state_t          state;
  state_t          stateNxt;
  logic [15:0]     base;
  logic [15:0]     wdataQ;
  logic            lastD;
  logic [CntW-1:0] issueCnt;
  logic [CntW-1:0] recvCnt;

  logic            filling;
  logic            issuing;
  logic            recving;
  logic            lastWord;
  logic            pickD;
  logic            pickI;
  logic [15:0]     issueOff;

  assign filling  = (state == FILL_I) || (state == FILL_D);
  assign issuing  = filling && (issueCnt < Full);
  assign recving  = filling && mem_valid;
  assign lastWord = recving && (recvCnt == LastIdx);
  assign issueOff = 16'({issueCnt[IdxW-1:0], 1'b0});

  // under contention the requester that did not win last time goes first
  always_comb begin
    pickD = 1'b0;
    pickI = 1'b0;
    unique case (1'b1)
      (i_req && d_req): begin
        pickD = !lastD;
        pickI = lastD;
      end
      (d_req && !i_req): pickD = 1'b1;
      (i_req && !d_req): pickI = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE: begin
        if (pickD)      stateNxt = d_wr ? WRITE : FILL_D;
        else if (pickI) stateNxt = FILL_I;
      end
      FILL_I,
      FILL_D: if (lastWord) stateNxt = IDLE;
      WRITE:  stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      base     <= '0;
      wdataQ   <= '0;
      lastD    <= 1'b0;
      issueCnt <= '0;
      recvCnt  <= '0;
    end else begin
      state <= stateNxt;
      if (state == IDLE) begin
        issueCnt <= '0;
        recvCnt  <= '0;
        if (pickD) begin
          lastD  <= 1'b1;
          base   <= d_wr ? d_addr : (d_addr & BlkMask);
          wdataQ <= d_wdata;
        end else if (pickI) begin
          lastD <= 1'b0;
          base  <= i_addr & BlkMask;
        end
      end else if (lastWord || (state == WRITE)) begin
        issueCnt <= '0;
        recvCnt  <= '0;
      end else begin
        if (issuing) issueCnt <= issueCnt + CntW'(1);
        if (recving) recvCnt  <= recvCnt + CntW'(1);
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (issuing) begin
      mem_en   = 1'b1;
      mem_addr = base + issueOff;
    end
    if (state == WRITE) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = base;
      mem_wdata = wdataQ;
    end
  end

  assign i_grant      = (state == FILL_I);
  assign d_grant      = (state == FILL_D) || (state == WRITE);
  assign fill_data    = mem_rdata;
  assign fill_idx     = recving ? recvCnt[IdxW-1:0] : '0;
  assign i_fill_valid = recving && (state == FILL_I);
  assign d_fill_valid = recving && (state == FILL_D);
  assign i_done       = lastWord && (state == FILL_I);
  assign d_done       = (lastWord && (state == FILL_D))
                     || (state == WRITE);

  // memory must return each word within MEM_LAT cycles of its issue
  a_latency: assert property (@(posedge clk) disable iff (!rst_n)
    recving |-> ((issueCnt - recvCnt) <= MaxOut));

  a_oneGrant: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_grant && d_grant));

  a_oneFill: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_fill_valid && d_fill_valid));

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb_cache_fill_arbiter: vector table, directed corner sequences and
// random traffic against an offset-timeline reference model.
module tb_cache_fill_arbiter;

  localparam int MEM_LAT = 4;
  localparam int WORDS   = 8;
  localparam int IW      = $clog2(WORDS);
  localparam int AW      = 56 + IW;

  logic          clk;
  logic          rst_n;
  logic          i_req;
  logic [15:0]   i_addr;
  logic          d_req;
  logic          d_wr;
  logic [15:0]   d_addr;
  logic [15:0]   d_wdata;
  logic          mem_en;
  logic          mem_wr;
  logic [15:0]   mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;
  logic          mem_valid;
  logic          i_grant;
  logic          d_grant;
  logic [15:0]   fill_data;
  logic [IW-1:0] fill_idx;
  logic          i_fill_valid;
  logic          d_fill_valid;
  logic          i_done;
  logic          d_done;

  cache_fill_arbiter #(
    .MEM_LAT(MEM_LAT),
    .WORDS  (WORDS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .d_req       (d_req),
    .d_wr        (d_wr),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .i_grant     (i_grant),
    .d_grant     (d_grant),
    .fill_data   (fill_data),
    .fill_idx    (fill_idx),
    .i_fill_valid(i_fill_valid),
    .d_fill_valid(d_fill_valid),
    .i_done      (i_done),
    .d_done      (d_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] memData(logic [15:0] a);
    return a ^ 16'hA55A;
  endfunction

  // fixed-latency memory, not cleared by the DUT reset
  logic               memRst;
  logic               noise;
  logic [MEM_LAT-1:0] pv;
  logic [15:0]        pa [MEM_LAT];

  always @(posedge clk) begin
    if (memRst) pv <= '0;
    else pv <= {pv[MEM_LAT-2:0], mem_en & ~mem_wr};
    pa[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) pa[i] <= pa[i-1];
  end

  assign mem_valid = pv[MEM_LAT-1] | noise;
  assign mem_rdata = pv[MEM_LAT-1] ? memData(pa[MEM_LAT-1])
                   : (noise ? 16'hBAD0 : 16'h0000);

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model: one operation at a time, tracked by cycle offset
  bit          mActive;
  bit          mOwnerD;
  bit          mWrite;
  bit          mLastD;
  logic [15:0] mBase;
  logic [15:0] mWdata;
  int          mOff;

  function automatic int lastOff();
    return mWrite ? 1 : WORDS + MEM_LAT;
  endfunction

  task automatic modelReset();
    mActive = 1'b0;
    mLastD  = 1'b0;
    mWrite  = 1'b0;
    mOff    = 0;
  endtask

  task automatic modelEdge();
    bit pickD;
    if (!rst_n) begin
      modelReset();
    end else if (mActive) begin
      if (mOff == lastOff()) mActive = 1'b0;
      else mOff++;
    end else if (i_req || d_req) begin
      pickD   = d_req && !(i_req && mLastD);
      mActive = 1'b1;
      mOff    = 1;
      mOwnerD = pickD;
      mLastD  = pickD;
      mWrite  = pickD && d_wr;
      mWdata  = d_wdata;
      if (mWrite) mBase = d_addr;
      else mBase = (pickD ? d_addr : i_addr) & ~16'(2*WORDS-1);
    end
  endtask

  function automatic logic [AW-1:0] expOut();
    logic en, wr, ig, dg, ifv, dfv, idn, ddn;
    logic [15:0] a, wd, fd;
    logic [IW-1:0] idx;
    int j;
    en = 0; wr = 0; ig = 0; dg = 0;
    ifv = 0; dfv = 0; idn = 0; ddn = 0;
    a = '0; wd = '0; idx = '0;
    fd = mem_rdata;
    if (mActive) begin
      ig = !mOwnerD;
      dg = mOwnerD;
      if (mWrite) begin
        en = 1; wr = 1; a = mBase; wd = mWdata; ddn = 1;
      end else begin
        if (mOff <= WORDS) begin
          en = 1;
          a  = mBase + 16'(2 * (mOff - 1));
        end
        if (mOff > MEM_LAT && mOff <= WORDS + MEM_LAT) begin
          j   = mOff - 1 - MEM_LAT;
          idx = IW'(j);
          fd  = memData(mBase + 16'(2 * j));
          if (mOwnerD) dfv = 1; else ifv = 1;
          if (mOff == WORDS + MEM_LAT) begin
            if (mOwnerD) ddn = 1; else idn = 1;
          end
        end
      end
    end
    return {en, wr, a, wd, ig, dg, idx, ifv, dfv, idn, ddn, fd};
  endfunction

  function automatic logic [AW-1:0] actOut();
    return {mem_en, mem_wr, mem_addr, mem_wdata, i_grant, d_grant,
            fill_idx, i_fill_valid, d_fill_valid, i_done, d_done,
            fill_data};
  endfunction

  task automatic cmp(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic chk(string n);
    logic [AW-1:0] a, e;
    #2;
    a = actOut();
    e = expOut();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc %0d: got %h want %h", n, cyc, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    cyc++;
    #1;
  endtask

  task automatic idle(int n, string name);
    repeat (n) begin
      tick();
      chk(name);
    end
  endtask

  typedef struct {
    bit          useI;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          dropAt;
    logic [15:0] expFirst;
    logic [15:0] expLast;
    int          expIssues;
    int          expFv;
    int          expDone;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [AW-1:0] v;
    int owners [4];
    int ng, fv, firstOwner, dDoneCyc, igCyc, gotDone;
    bit prevG, g;

    tbl[0] = '{1'b1, 1'b0, 16'h1236, 16'h0000, 0,
               16'h1230, 16'h123E, 8, 8, 12};
    tbl[1] = '{1'b0, 1'b0, 16'h8004, 16'h0000, 0,
               16'h8000, 16'h800E, 8, 8, 12};
    tbl[2] = '{1'b0, 1'b1, 16'h00A2, 16'hBEEF, 0,
               16'h00A2, 16'h00A2, 1, 0, 1};
    tbl[3] = '{1'b1, 1'b0, 16'hFFF4, 16'h0000, 3,
               16'hFFF0, 16'hFFFE, 8, 8, 12};
    tbl[4] = '{1'b0, 1'b0, 16'h000F, 16'h1111, 0,
               16'h0000, 16'h000E, 8, 8, 12};

    rst_n = 1'b0; memRst = 1'b1; noise = 1'b0;
    i_req = 0; i_addr = '0; d_req = 0; d_wr = 0;
    d_addr = '0; d_wdata = '0;
    modelReset();
    tick();
    memRst = 1'b0;
    tick();
    v = actOut();
    cmp("reset_outs", 64'(v[AW-1:16]), 64'd0);
    chk("reset");
    rst_n = 1'b1;
    idle(2, "post_reset");

    // contention straight after reset: D first, I two cycles after d_done
    i_req = 1; i_addr = 16'h1236;
    d_req = 1; d_wr = 0; d_addr = 16'h8004;
    firstOwner = 0; dDoneCyc = -100; igCyc = -1;
    for (int n = 0; n < 60 && igCyc < 0; n++) begin
      tick();
      chk("cont");
      if (firstOwner == 0 && (i_grant || d_grant))
        firstOwner = d_grant ? 2 : 1;
      if (d_done) begin
        dDoneCyc = cyc;
        d_req = 0;
      end
      if (i_grant) igCyc = cyc;
    end
    cmp("cont_first_is_D", 64'(firstOwner), 64'd2);
    cmp("cont_i_gap", 64'(igCyc - dDoneCyc), 64'd2);
    gotDone = 0;
    for (int n = 0; n < 30 && gotDone == 0; n++) begin
      tick();
      chk("cont_i");
      if (i_done) gotDone = 1;
    end
    i_req = 0;
    cmp("cont_i_done", 64'(gotDone), 64'd1);
    idle(2, "cont_idle");

    // fairness: both requests held continuously
    i_req = 1; i_addr = 16'h2000;
    d_req = 1; d_wr = 0; d_addr = 16'h4000;
    ng = 0; prevG = 0;
    for (int n = 0; n < 200 && ng < 4; n++) begin
      tick();
      chk("fair");
      g = i_grant | d_grant;
      if (g && !prevG) begin
        owners[ng] = d_grant ? 1 : 0;
        ng++;
      end
      prevG = g;
    end
    i_req = 0; d_req = 0;
    cmp("fair_count", 64'(ng), 64'd4);
    for (int k = 0; k < 4; k++)
      if (k < ng) cmp($sformatf("fair_owner%0d", k),
                      64'(owners[k]), 64'((k % 2 == 0) ? 1 : 0));
    idle(16, "fair_drain");

    // single operations from the vector table
    for (int t = 0; t < 5; t++) begin
      int n, issues, fvc, doneOff, doneI;
      logic [15:0] firstA, lastA, firstWd;
      if (tbl[t].useI) begin
        i_req = 1; i_addr = tbl[t].addr;
      end else begin
        d_req = 1; d_wr = tbl[t].wr;
        d_addr = tbl[t].addr; d_wdata = tbl[t].wdata;
      end
      n = 0; issues = 0; fvc = 0; doneOff = 0; doneI = 0;
      firstA = '0; lastA = '0; firstWd = '0;
      while (doneOff == 0 && n < 40) begin
        tick();
        n++;
        chk($sformatf("vec%0d", t));
        if (mem_en) begin
          if (issues == 0) begin
            firstA = mem_addr;
            firstWd = mem_wdata;
          end
          lastA = mem_addr;
          issues++;
          if (issues == tbl[t].dropAt) begin
            i_req = 0; d_req = 0;
          end
        end
        if (i_fill_valid || d_fill_valid) fvc++;
        if (i_done || d_done) begin
          doneOff = n;
          doneI = i_done ? 1 : 0;
        end
      end
      i_req = 0; d_req = 0;
      cmp($sformatf("vec%0d_first", t), 64'(firstA),
          64'(tbl[t].expFirst));
      cmp($sformatf("vec%0d_last", t), 64'(lastA),
          64'(tbl[t].expLast));
      cmp($sformatf("vec%0d_wdata", t), 64'(firstWd),
          64'(tbl[t].wr ? tbl[t].wdata : 16'h0000));
      cmp($sformatf("vec%0d_issues", t), 64'(issues),
          64'(tbl[t].expIssues));
      cmp($sformatf("vec%0d_fills", t), 64'(fvc),
          64'(tbl[t].expFv));
      cmp($sformatf("vec%0d_doneoff", t), 64'(doneOff),
          64'(tbl[t].expDone));
      cmp($sformatf("vec%0d_doneside", t), 64'(doneI),
          64'(tbl[t].useI));
      idle(2, "vec_idle");
    end

    // reset in the middle of a fill, then stale returns, then refill
    i_req = 1; i_addr = 16'h1236; fv = 0;
    for (int n = 0; n < 30 && fv < 3; n++) begin
      tick();
      chk("rmf");
      if (i_fill_valid) fv++;
    end
    i_req = 0;
    #1 rst_n = 1'b0;
    modelReset();
    #1;
    v = actOut();
    cmp("rst_mid_outs", 64'(v[AW-1:16]), 64'd0);
    chk("rst_mid");
    tick();
    chk("rst_hold");
    rst_n = 1'b1;
    fv = 0;
    for (int n = 0; n < MEM_LAT + 3; n++) begin
      tick();
      noise = (n == MEM_LAT + 1);
      chk("stale");
      if (i_fill_valid || d_fill_valid) fv++;
    end
    noise = 0;
    cmp("stale_dropped", 64'(fv), 64'd0);
    i_req = 1; i_addr = 16'h3456;
    fv = -1; gotDone = 0;
    for (int n = 0; n < 30 && gotDone == 0; n++) begin
      tick();
      chk("refill");
      if (i_fill_valid && fv < 0) fv = int'(fill_idx);
      if (i_done) gotDone = 1;
    end
    i_req = 0;
    cmp("refill_idx0", 64'(fv), 64'd0);
    cmp("refill_done", 64'(gotDone), 64'd1);
    idle(2, "refill_idle");

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (mActive && mOff == lastOff()) begin
        if (mOwnerD) d_req = 0; else i_req = 0;
      end
      if (mActive && !mWrite && mOff == 3
          && $urandom_range(0, 3) == 0) begin
        if (mOwnerD) d_req = 0; else i_req = 0;
      end
      if (!i_req && $urandom_range(0, 3) == 0) begin
        i_req = 1; i_addr = 16'($urandom);
      end
      if (!d_req && $urandom_range(0, 3) == 0) begin
        d_req = 1;
        d_wr = ($urandom_range(0, 2) == 0);
        d_addr = 16'($urandom);
        d_wdata = 16'($urandom);
      end
      noise = (!mActive || mWrite) && ($urandom_range(0, 5) == 0);
      chk("rand");
    end
    i_req = 0; d_req = 0; noise = 0;
    idle(20, "rand_drain");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
